ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
EX/MEM pipeline register of the 5-stage MIPS core, directly downstream of the 5-bit destination-register select mux (rt/rd chosen by RegDst).
- Captures the selected destination register together with the EX-stage ALU result, store data and the MEM/WB control bits.
- Presents them registered to the MEM stage and to the forwarding unit.
- Supports stall (hold), flush (bubble insertion) and a per-entry valid bit.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_W, 5, width of register specifier
CNT_W, 16, width of optional performance counters

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold current contents (MEM stage busy / hazard unit)
flush  input  1  replace next contents with a bubble
valid_in  input  1  EX stage holds a real instruction
alu_result_in  input  DATA_W  EX ALU result / effective address
store_data_in  input  DATA_W  forwarded rt value for sw
write_reg_in  input  REG_W  destination register from RegDst mux output
reg_write_in  input  1  WB writes register file
mem_to_reg_in  input  1  WB selects load data
mem_read_in  input  1  load
mem_write_in  input  1  store
valid_out  output  1  MEM stage holds a real instruction
alu_result_out  output  DATA_W  registered ALU result
store_data_out  output  DATA_W  registered store data
write_reg_out  output  REG_W  registered destination register
reg_write_out  output  1  qualified register write enable
mem_to_reg_out  output  1  registered mem_to_reg
mem_read_out  output  1  qualified load strobe
mem_write_out  output  1  qualified store strobe
fwd_load_pending  output  1  valid load in MEM targeting a nonzero register (to hazard unit)
stall_cnt  output  CNT_W  stall cycles (only with EXMEM_PERF_CNT_EN)
flush_cnt  output  CNT_W  flushes (only with EXMEM_PERF_CNT_EN)

Behaviour:
- Reset is synchronous and active-high; the block runs on the single clock clk.
- Reset: all outputs 0, i.e. valid_out=0, data and write_reg 0, all control 0, counters 0.
- Priority at each rising edge: rst > flush > stall > load.
- flush: valid_out=0 and all control outputs 0. Data and write_reg outputs also clear to 0, so the bubble is deterministic.
- stall (flush=0): every register holds its value, including valid_out. Inputs are ignored.
- Load (no rst/flush/stall): all fields are captured with 1-cycle latency. valid_out=valid_in.
- Qualification at capture:
  - reg_write_out = reg_write_in & valid_in & (write_reg_in != 0); writes to $zero are suppressed.
  - mem_read_out = mem_read_in & valid_in.
  - mem_write_out = mem_write_in & valid_in.
- mem_read_in and mem_write_in both 1 is illegal. The block captures both unchanged; the assertion for this is described under Test Plan.
- mem_to_reg_out is captured raw; WB ignores it when reg_write_out=0.
- fwd_load_pending is combinational from the registered state: valid_out & mem_read_out & (write_reg_out != 0).
- flush and stall in the same cycle: flush wins; stall_cnt is not incremented.
- rst with flush/stall in the same cycle: reset wins.
- Stall of arbitrary length: contents remain bit-identical for the whole stall.
- No combinational path from any input to any output.

Optional Feature:
Macro EXMEM_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each edge with stall=1 & flush=0 & rst=0.
  - flush_cnt increments on each edge with flush=1 & rst=0.
  - Both saturate at all-ones (no wrap) and clear on rst.
- Not defined: stall_cnt and flush_cnt are tied to 0. No counter flops are synthesized.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs -> all outputs 0, valid_out=0, counters 0.
2. Load: valid_in=1, alu_result_in=0x0000_1004, write_reg_in=8, reg_write_in=1, mem_read_in=1, mem_to_reg_in=1 -> next cycle outputs match, reg_write_out=1, fwd_load_pending=1.
3. $zero suppression: write_reg_in=0, reg_write_in=1, mem_read_in=1, valid_in=1 -> reg_write_out=0, fwd_load_pending=0, mem_read_out=1.
4. Stall: after loading write_reg_in=17 and alu_result_in=0xDEAD_BEEF, hold stall=1 for 3 cycles while changing inputs -> outputs unchanged for 3 cycles. With the macro defined, stall_cnt=3.
5. Flush vs stall: stall=1 and flush=1 together while a valid sw is held -> next cycle valid_out=0, mem_write_out=0, all fields 0. With the macro, flush_cnt=1 and stall_cnt unchanged.
6. Invalid entry: valid_in=0, mem_write_in=1, reg_write_in=1, write_reg_in=5 -> mem_write_out=0, reg_write_out=0, valid_out=0. Bench also asserts mem_read_out & mem_write_out is never 1.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures the EX-stage result, store data, destination register and MEM/WB control.
// Optional stall/flush performance counters are enabled by defining EXMEM_PERF_CNT_EN.
module ex_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [REG_W-1:0]  write_reg_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [REG_W-1:0]  write_reg_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              fwd_load_pending,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    function automatic logic reg_nonzero(input logic [REG_W-1:0] r);
        return (r != {REG_W{1'b0}});
    endfunction

    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [REG_W-1:0]  write_reg_q,  write_reg_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              fwd_load_q,   fwd_load_d;

    // Next-state selection: flush inserts an all-zero bubble, stall holds, otherwise capture qualified inputs.
    always_comb begin
        valid_d      = valid_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        write_reg_d  = write_reg_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        if (flush) begin
            valid_d      = 1'b0;
            alu_result_d = {DATA_W{1'b0}};
            store_data_d = {DATA_W{1'b0}};
            write_reg_d  = {REG_W{1'b0}};
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
        end else if (stall) begin
            valid_d      = valid_q;
            alu_result_d = alu_result_q;
            store_data_d = store_data_q;
            write_reg_d  = write_reg_q;
            reg_write_d  = reg_write_q;
            mem_to_reg_d = mem_to_reg_q;
            mem_read_d   = mem_read_q;
            mem_write_d  = mem_write_q;
        end else begin
            valid_d      = valid_in;
            alu_result_d = alu_result_in;
            store_data_d = store_data_in;
            write_reg_d  = write_reg_in;
            reg_write_d  = reg_write_in & valid_in & reg_nonzero(write_reg_in);
            mem_to_reg_d = mem_to_reg_in;
            mem_read_d   = mem_read_in & valid_in;
            mem_write_d  = mem_write_in & valid_in;
        end
        // Precomputed from next state so the hazard-unit signal leaves a flop.
        fwd_load_d = valid_d & mem_read_d & reg_nonzero(write_reg_d);
    end

    // Pipeline state flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            alu_result_q <= {DATA_W{1'b0}};
            store_data_q <= {DATA_W{1'b0}};
            write_reg_q  <= {REG_W{1'b0}};
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            fwd_load_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            fwd_load_q   <= fwd_load_d;
        end
    end

    assign valid_out        = valid_q;
    assign alu_result_out   = alu_result_q;
    assign store_data_out   = store_data_q;
    assign write_reg_out    = write_reg_q;
    assign reg_write_out    = reg_write_q;
    assign mem_to_reg_out   = mem_to_reg_q;
    assign mem_read_out     = mem_read_q;
    assign mem_write_out    = mem_write_q;
    assign fwd_load_pending = fwd_load_q;

`ifdef EXMEM_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A stall overridden by flush is not counted as a stall cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Saturating counter flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg; a reference model pushes expected state each cycle, tasks pop and compare.
module tb_ex_mem_pipe_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
`ifdef EXMEM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sd;
        logic [REG_W-1:0]  wr;
        logic              rw;
        logic              m2r;
        logic              mr;
        logic              mw;
        logic              fwd;
        logic [CNT_W-1:0]  sc;
        logic [CNT_W-1:0]  fc;
    } out_t;

    logic clk = 1'b0;
    logic rst, stall, flush, valid_in, reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in;
    logic [DATA_W-1:0] alu_result_in, store_data_in;
    logic [REG_W-1:0]  write_reg_in;
    logic valid_out, reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out, fwd_load_pending;
    logic [DATA_W-1:0] alu_result_out, store_data_out;
    logic [REG_W-1:0]  write_reg_out;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    out_t m;
    out_t sb[$];
    out_t exp_s, got_s;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in), .write_reg_in(write_reg_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .valid_out(valid_out), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .write_reg_out(write_reg_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .fwd_load_pending(fwd_load_pending), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic out_t observe();
        return '{valid_out, alu_result_out, store_data_out, write_reg_out, reg_write_out,
                 mem_to_reg_out, mem_read_out, mem_write_out, fwd_load_pending, stall_cnt, flush_cnt};
    endfunction

    task automatic rand_inputs();
        valid_in      = 1'($urandom);
        alu_result_in = $urandom;
        store_data_in = $urandom;
        write_reg_in  = 5'($urandom);
        reg_write_in  = 1'($urandom);
        mem_to_reg_in = 1'($urandom);
        mem_read_in   = 1'($urandom);
        mem_write_in  = mem_read_in ? 1'b0 : 1'($urandom);
    endtask

    // Advance the model from the current inputs, push the expectation, then cross the clock edge.
    task automatic step();
        if (rst) begin
            m = '0;
        end else if (flush) begin
            m.v = 1'b0; m.alu = '0; m.sd = '0; m.wr = '0;
            m.rw = 1'b0; m.m2r = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.fwd = 1'b0;
            if (PERF && m.fc != 4'hF) m.fc = m.fc + 4'd1;
        end else if (stall) begin
            if (PERF && m.sc != 4'hF) m.sc = m.sc + 4'd1;
        end else begin
            m.v   = valid_in;
            m.alu = alu_result_in;
            m.sd  = store_data_in;
            m.wr  = write_reg_in;
            m.rw  = reg_write_in && valid_in && (write_reg_in != 5'd0);
            m.m2r = mem_to_reg_in;
            m.mr  = mem_read_in && valid_in;
            m.mw  = mem_write_in && valid_in;
            m.fwd = m.v && m.mr && (m.wr != 5'd0);
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        checks++;
        if ((mem_read_out & mem_write_out) !== 1'b0) begin
            errors++;
            $display("FAIL rd_wr_exclusive: mem_read_out=%b mem_write_out=%b required not both 1", mem_read_out, mem_write_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'($urandom); flush = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            step();
            exp_s = sb.pop_front(); got_s = observe(); checks++;
            if (got_s !== exp_s) begin errors++; $display("FAIL reset_state: got %h required %h", got_s, exp_s); end
            checks++;
            if (got_s !== '0) begin errors++; $display("FAIL reset_zero: got %h required 0", got_s); end
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_load();
        valid_in = 1'b1; alu_result_in = 32'h0000_1004; store_data_in = 32'h1234_5678; write_reg_in = 5'd8;
        reg_write_in = 1'b1; mem_read_in = 1'b1; mem_to_reg_in = 1'b1; mem_write_in = 1'b0;
        step();
        exp_s = sb.pop_front(); got_s = observe(); checks++;
        if (got_s !== exp_s) begin errors++; $display("FAIL load: got %h required %h", got_s, exp_s); end
        checks++;
        if ({valid_out, reg_write_out, fwd_load_pending, write_reg_out, alu_result_out} !== {3'b111, 5'd8, 32'h0000_1004}) begin
            errors++;
            $display("FAIL load_fields: v=%b rw=%b fwd=%b wr=%0d alu=%h required 1 1 1 8 00001004",
                     valid_out, reg_write_out, fwd_load_pending, write_reg_out, alu_result_out);
        end
    endtask

    task automatic test_zero_suppress();
        valid_in = 1'b1; write_reg_in = 5'd0; reg_write_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        step();
        exp_s = sb.pop_front(); got_s = observe(); checks++;
        if (got_s !== exp_s) begin errors++; $display("FAIL zero_reg: got %h required %h", got_s, exp_s); end
        checks++;
        if ({reg_write_out, fwd_load_pending, mem_read_out} !== 3'b001) begin
            errors++;
            $display("FAIL zero_reg_fields: rw=%b fwd=%b mr=%b required 0 0 1", reg_write_out, fwd_load_pending, mem_read_out);
        end
    endtask

    task automatic test_stall();
        logic [CNT_W-1:0] sc0;
        valid_in = 1'b1; write_reg_in = 5'd17; alu_result_in = 32'hDEAD_BEEF; reg_write_in = 1'b1;
        mem_read_in = 1'b0; mem_write_in = 1'b0;
        step();
        exp_s = sb.pop_front(); got_s = observe(); checks++;
        if (got_s !== exp_s) begin errors++; $display("FAIL stall_load: got %h required %h", got_s, exp_s); end
        sc0 = stall_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
            exp_s = sb.pop_front(); got_s = observe(); checks++;
            if (got_s !== exp_s) begin errors++; $display("FAIL stall_hold: got %h required %h", got_s, exp_s); end
            checks++;
            if ({alu_result_out, write_reg_out, valid_out} !== {32'hDEAD_BEEF, 5'd17, 1'b1}) begin
                errors++;
                $display("FAIL stall_fields: alu=%h wr=%0d v=%b required deadbeef 17 1", alu_result_out, write_reg_out, valid_out);
            end
        end
        stall = 1'b0;
        checks++;
        if (4'(stall_cnt - sc0) !== (PERF ? 4'd3 : 4'd0)) begin
            errors++; $display("FAIL stall_cnt: delta %0d required %0d", 4'(stall_cnt - sc0), PERF ? 3 : 0);
        end
    endtask

    task automatic test_flush_vs_stall();
        logic [CNT_W-1:0] sc0, fc0;
        valid_in = 1'b1; mem_write_in = 1'b1; mem_read_in = 1'b0; reg_write_in = 1'b0;
        alu_result_in = 32'h0000_2000; store_data_in = 32'hCAFE_F00D; write_reg_in = 5'd9;
        step();
        exp_s = sb.pop_front(); got_s = observe(); checks++;
        if (got_s !== exp_s) begin errors++; $display("FAIL sw_load: got %h required %h", got_s, exp_s); end
        sc0 = stall_cnt; fc0 = flush_cnt;
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        exp_s = sb.pop_front(); got_s = observe(); checks++;
        if (got_s !== exp_s) begin errors++; $display("FAIL flush_stall: got %h required %h", got_s, exp_s); end
        checks++;
        if ({valid_out, mem_write_out, alu_result_out, store_data_out, write_reg_out} !== '0) begin
            errors++; $display("FAIL flush_fields: v=%b mw=%b alu=%h sd=%h wr=%0d required all 0",
                               valid_out, mem_write_out, alu_result_out, store_data_out, write_reg_out);
        end
        checks++;
        if ({4'(flush_cnt - fc0), 4'(stall_cnt - sc0)} !== {(PERF ? 4'd1 : 4'd0), 4'd0}) begin
            errors++; $display("FAIL flush_cnt: flush delta %0d stall delta %0d required %0d 0",
                               4'(flush_cnt - fc0), 4'(stall_cnt - sc0), PERF ? 1 : 0);
        end
    endtask

    task automatic test_invalid();
        valid_in = 1'b0; mem_write_in = 1'b1; mem_read_in = 1'b0; reg_write_in = 1'b1; write_reg_in = 5'd5;
        step();
        exp_s = sb.pop_front(); got_s = observe(); checks++;
        if (got_s !== exp_s) begin errors++; $display("FAIL invalid: got %h required %h", got_s, exp_s); end
        checks++;
        if ({mem_write_out, reg_write_out, valid_out} !== 3'b000) begin
            errors++; $display("FAIL invalid_fields: mw=%b rw=%b v=%b required 0 0 0", mem_write_out, reg_write_out, valid_out);
        end
    endtask

    task automatic test_saturation();
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_inputs(); step();
            exp_s = sb.pop_front(); got_s = observe(); checks++;
            if (got_s !== exp_s) begin errors++; $display("FAIL sat_stall: got %h required %h", got_s, exp_s); end
        end
        stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_inputs(); step();
            exp_s = sb.pop_front(); got_s = observe(); checks++;
            if (got_s !== exp_s) begin errors++; $display("FAIL sat_flush: got %h required %h", got_s, exp_s); end
        end
        flush = 1'b0;
        checks++;
        if ({stall_cnt, flush_cnt} !== (PERF ? 8'hFF : 8'h00)) begin
            errors++; $display("FAIL saturate: stall_cnt=%0d flush_cnt=%0d required %0d", stall_cnt, flush_cnt, PERF ? 15 : 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 19) == 0);
            step();
            exp_s = sb.pop_front(); got_s = observe(); checks++;
            if (got_s !== exp_s) begin errors++; $display("FAIL b2b[%0d]: got %h required %h", i, got_s, exp_s); end
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        m = '0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rand_inputs();
        test_reset();
        test_load();
        test_zero_suppress();
        test_stall();
        test_flush_vs_stall();
        test_invalid();
        test_saturation();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
